// File: rtl/rc_stim_sequencer.sv
// rc_stim_sequencer: drives a programmable square wave into a clk-synchronous
// analog model and times each model-output transition against the drive edge
// that caused it, reporting per-edge delays and a count of unanswered edges.
module rc_stim_sequencer #(
  parameter int CW = 16,
  parameter int FW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] half_period,
  input  logic [FW-1:0] num_flips,
  output logic          drive_in,
  input  logic          out_sense,
  output logic          busy,
  output logic          done,
  output logic          meas_valid,
  output logic          meas_rise,
  output logic [DW-1:0] meas_delay,
  output logic [DW-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] hp_q;
  logic [CW-1:0] phase;
  logic [FW-1:0] nf_q;
  logic [FW-1:0] flips;
  logic          armed;
  logic [DW-1:0] dly;

  logic          match;
  logic          level_end;
  logic          cfg_ok;

  // Saturating increment shared by the delay counter and the miss counter.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (v == {DW{1'b1}}) ? v : v + DW'(1);
  endfunction

  // Per-cycle decode: response match while armed, end of the current drive level.
  always_comb begin
    match     = armed && (out_sense == drive_in);
    level_end = (phase == hp_q - CW'(1));
    cfg_ok    = (half_period != '0) && (num_flips != '0);
  end

  // Sequencer FSM with registered drive, status and measurement outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hp_q       <= '0;
      nf_q       <= '0;
      phase      <= '0;
      flips      <= '0;
      armed      <= 1'b0;
      dly        <= '0;
      drive_in   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      meas_valid <= 1'b0;
      meas_rise  <= 1'b0;
      meas_delay <= '0;
      miss_count <= '0;
    end else begin
      done       <= 1'b0;
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          armed <= 1'b0;
          if (start && cfg_ok) begin
            hp_q       <= half_period;
            nf_q       <= num_flips;
            phase      <= '0;
            flips      <= '0;
            miss_count <= '0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN, TAIL: begin
          if (abort) begin
            // Abort wins over toggle/done; a pending capture is simply dropped.
            state    <= IDLE;
            busy     <= 1'b0;
            drive_in <= 1'b0;
            armed    <= 1'b0;
          end else begin
            if (match) begin
              meas_valid <= 1'b1;
              meas_rise  <= drive_in;
              meas_delay <= dly;
            end
            // A match on the closing cycle of a window still counts as a capture.
            if (level_end && armed && !match) begin
              miss_count <= sat_inc(miss_count);
            end
            phase <= level_end ? '0 : phase + CW'(1);
            if (level_end && (state == RUN)) begin
              drive_in <= ~drive_in;
              flips    <= flips + FW'(1);
              armed    <= 1'b1;
              dly      <= DW'(1);
              if (flips == nf_q - FW'(1)) begin
                state <= TAIL;
              end
            end else begin
              dly <= sat_inc(dly);
              if (match || (level_end && (state == TAIL))) begin
                armed <= 1'b0;
              end
              if (level_end && (state == TAIL)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule
